// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package rf_arb_pkg;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int MAX_BURST = 4;
   localparam int ID_W      = $clog2(NUM_REQ);

   // Burst counter is wide enough for the largest legal MAX_BURST (15).
   localparam int BURST_W   = 4;

   typedef logic [ID_W-1:0]    req_id_t;
   typedef logic [BURST_W-1:0] burst_cnt_t;

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Rotating priority encoder: the first set request at or above ptr
// (modulo N) wins. With no request the index falls back to ptr.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   // Scan offsets from farthest to nearest so the nearest active request is the last one written.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      gnt = '0;
      idx = ptr;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            gnt                          = '0;
            gnt[(int'(ptr) + i) % N]     = 1'b1;
            idx                          = IDX_W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the shared register-file read port. Grants one
// requester per cycle, drives the read-mux select, and returns a registered,
// tagged response one cycle later. A locked requester may hold the port for
// up to MAX_BURST back-to-back reads.
module rf_read_arbiter #(
   parameter int NUM_REQ   = rf_arb_pkg::NUM_REQ,
   parameter int DATA_W    = rf_arb_pkg::DATA_W,
   parameter int ADDR_W    = rf_arb_pkg::ADDR_W,
   parameter int MAX_BURST = rf_arb_pkg::MAX_BURST,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ-1:0]        i_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   input  logic                      i_stall,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic [ADDR_W-1:0]         o_rf_addr,
   input  logic [DATA_W-1:0]         i_rf_data,
   output logic                      o_rsp_valid,
   output logic [ID_W-1:0]           o_rsp_id,
   output logic [DATA_W-1:0]         o_rsp_data
);

   import rf_arb_pkg::*;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    last_id;
   burst_cnt_t         burst_cnt;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    addr_id;
   logic [ID_W-1:0]    next_ptr;
   logic               lock_win;
   logic               grant_en;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req (i_req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Resolve lock override against the round-robin pick and drive grant and read select.
   always_comb begin
      // A non-zero burst_cnt means last_id was granted in the previous cycle.
      lock_win  = (burst_cnt != '0) && (burst_cnt < BURST_W'(MAX_BURST))
                  && i_req[last_id] && i_lock[last_id];
      grant_en  = (|i_req) && !i_stall && !i_rst;
      winner    = lock_win ? last_id : pick_idx;
      next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      o_gnt     = '0;
      if (grant_en) begin
         if (lock_win) begin
            o_gnt[last_id] = 1'b1;
         end else begin
            o_gnt = pick_gnt;
         end
      end
      // Without a grant the select parks on rr_ptr so the mux never sees X.
      addr_id   = grant_en ? winner : rr_ptr;
      o_rf_addr = i_addr[addr_id*ADDR_W +: ADDR_W];
   end

   // Arbitration state: rotate priority, remember the last winner, count its run length.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
      if (i_rst) begin
         rr_ptr    <= '0;
         last_id   <= '0;
         burst_cnt <= '0;
      end else if (grant_en) begin
         if (!lock_win) begin
            rr_ptr <= next_ptr;
         end
         last_id <= winner;
         if ((winner == last_id) && (burst_cnt != '0)) begin
            // Saturate so a long sole-requester run cannot wrap back to "no previous grant".
            if (burst_cnt != '1) begin
               burst_cnt <= burst_cnt + 1'b1;
            end
         end else begin
            burst_cnt <= BURST_W'(1);
         end
      end else begin
         burst_cnt <= '0;
      end
   end

   // Response register: tag and data are captured only on granted cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_data  <= '0;
      end else begin
         o_rsp_valid <= grant_en;
         if (grant_en) begin
            o_rsp_id   <= winner;
            o_rsp_data <= i_rf_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter: a cycle-level behavioural model
// checked on every falling edge, plus directed scenarios with literal values.
module tb_rf_read_arbiter;

   localparam int N      = 4;
   localparam int AW     = 5;
   localparam int DW     = 32;
   localparam int MAXB   = 4;

   logic            clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [N-1:0]    i_req = '0;
   logic [N-1:0]    i_lock = '0;
   logic            i_stall = 1'b0;
   logic [N*AW-1:0] i_addr;
   logic [N-1:0]    o_gnt;
   logic [AW-1:0]   o_rf_addr;
   logic [DW-1:0]   i_rf_data;
   logic            o_rsp_valid;
   logic [1:0]      o_rsp_id;
   logic [DW-1:0]   o_rsp_data;

   logic [AW-1:0]   addr [N];
   logic [DW-1:0]   regs [32];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign i_addr    = {addr[3], addr[2], addr[1], addr[0]};
   assign i_rf_data = regs[o_rf_addr];

   rf_read_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .MAX_BURST (MAXB)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_lock      (i_lock),
      .i_addr      (i_addr),
      .i_stall     (i_stall),
      .o_gnt       (o_gnt),
      .o_rf_addr   (o_rf_addr),
      .i_rf_data   (i_rf_data),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_id    (o_rsp_id),
      .o_rsp_data  (o_rsp_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs just after the rising edge, then let outputs settle.
   task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic stall, input logic rst);
      @(posedge clk);
      #1;
      i_req   = req;
      i_lock  = lock;
      i_stall = stall;
      i_rst   = rst;
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // m_run: number of consecutive cycles m_last has just been granted (0 = not granted last cycle).
   int          m_ptr = 0;
   int          m_last = 0;
   int          m_run = 0;
   bit          m_rsp_valid = 1'b0;
   int          m_rsp_id = 0;
   logic [31:0] m_rsp_data = '0;
   int          w_win;
   bit          w_lock_hit;
   logic [N-1:0] w_gnt;
   logic [N-1:0] w_one;

   always @(negedge clk) begin
      check("rsp_valid", o_rsp_valid, m_rsp_valid);
      check("rsp_id", o_rsp_id, m_rsp_id);
      check("rsp_data", o_rsp_data, m_rsp_data);
      check("rf_addr_known", $isunknown(o_rf_addr), 0);

      w_win      = -1;
      w_lock_hit = 1'b0;
      if (!i_rst && !i_stall && (i_req != '0)) begin
         if (m_run > 0 && m_run < MAXB && i_req[m_last] && i_lock[m_last]) begin
            w_win      = m_last;
            w_lock_hit = 1'b1;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (w_win < 0 && i_req[(m_ptr + k) % N]) w_win = (m_ptr + k) % N;
            end
         end
      end
      w_one = 1;
      w_gnt = (w_win >= 0) ? (w_one << w_win) : '0;
      check("gnt", o_gnt, w_gnt);
      if (w_win >= 0) check("rf_addr", o_rf_addr, addr[w_win]);

      if (i_rst) begin
         m_ptr       = 0;
         m_last      = 0;
         m_run       = 0;
         m_rsp_valid = 1'b0;
         m_rsp_id    = 0;
         m_rsp_data  = '0;
      end else if (w_win >= 0) begin
         m_rsp_valid = 1'b1;
         m_rsp_id    = w_win;
         m_rsp_data  = regs[addr[w_win]];
         m_run       = (w_win == m_last && m_run > 0) ? m_run + 1 : 1;
         m_last      = w_win;
         if (!w_lock_hit) m_ptr = (w_win + 1) % N;
      end else begin
         m_rsp_valid = 1'b0;
         m_run       = 0;
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   logic [N-1:0] exp_g;
   logic [N-1:0] lock_seq [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
   logic [N-1:0] bit0;

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = (32'(r) * 32'h0101_0101) ^ 32'h5A5A_0000;
      regs[7]  = 32'hDEAD_BEEF;
      addr[0]  = 5'd3;
      addr[1]  = 5'd7;
      addr[2]  = 5'd12;
      addr[3]  = 5'd31;
      bit0     = 4'b0001;

      // Reset state
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b1111, 4'b0000, 1'b0, 1'b1);
      check("lit_reset_gnt", o_gnt, 4'b0000);
      check("lit_reset_valid", o_rsp_valid, 0);
      check("lit_reset_id", o_rsp_id, 0);
      check("lit_reset_data", o_rsp_data, 0);

      // Single request from requester 1 reading x7
      step(4'b0010, 4'b0000, 1'b0, 1'b0);
      check("lit_single_gnt", o_gnt, 4'b0010);
      check("lit_single_addr", o_rf_addr, 5'd7);
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("lit_single_valid", o_rsp_valid, 1);
      check("lit_single_id", o_rsp_id, 1);
      check("lit_single_data", o_rsp_data, 32'hDEAD_BEEF);
      check("lit_idle_gnt", o_gnt, 4'b0000);

      // All four requesting from reset: 0,1,2,3,0,1,2,3
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(4'b1111, 4'b0000, 1'b0, 1'b0);
         exp_g = bit0 << (i % 4);
         check("lit_rot_gnt", o_gnt, exp_g);
         if (i > 0) check("lit_rot_rsp_id", o_rsp_id, (i - 1) % 4);
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("lit_rot_last_id", o_rsp_id, 3);

      // Lock burst on requester 2: four grants, then 3, then 0
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b0100, 4'b0100, 1'b0, 1'b0);
      check("lit_lock_first", o_gnt, 4'b0100);
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, 4'b0100, 1'b0, 1'b0);
         check("lit_lock_seq", o_gnt, lock_seq[i]);
      end
      step(4'b1111, 4'b0100, 1'b0, 1'b0);
      check("lit_lock_after", o_gnt, 4'b0001);

      // Stall for two cycles; the pre-stall response still appears
      step(4'b1111, 4'b0000, 1'b0, 1'b0);
      check("lit_prestall_gnt", o_gnt, 4'b0010);
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      check("lit_stall1_gnt", o_gnt, 4'b0000);
      check("lit_stall1_valid", o_rsp_valid, 1);
      check("lit_stall1_id", o_rsp_id, 1);
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      check("lit_stall2_gnt", o_gnt, 4'b0000);
      check("lit_stall2_valid", o_rsp_valid, 0);
      step(4'b1111, 4'b0000, 1'b0, 1'b0);
      check("lit_poststall_gnt", o_gnt, 4'b0100);

      // Reset the cycle after a grant drops the in-flight response
      step(4'b1111, 4'b0000, 1'b0, 1'b0);
      check("lit_prerst_gnt", o_gnt, 4'b1000);
      step(4'b1111, 4'b0000, 1'b0, 1'b1);
      check("lit_rst_gnt", o_gnt, 4'b0000);
      check("lit_rst_valid_inflight", o_rsp_valid, 1);
      step(4'b1111, 4'b0000, 1'b0, 1'b0);
      check("lit_postrst_valid", o_rsp_valid, 0);
      check("lit_postrst_gnt", o_gnt, 4'b0001);

      // One-cycle stall ends a burst
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b0100, 4'b0100, 1'b0, 1'b0);
      step(4'b1111, 4'b0100, 1'b1, 1'b0);
      step(4'b1111, 4'b0100, 1'b0, 1'b0);
      check("lit_burst_broken", o_gnt, 4'b1000);

      // Wrap-around: 3 then 0 then pointer at 1; requester 0 presents a new address
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b1000, 4'b0000, 1'b0, 1'b0);
      check("lit_wrap_3", o_gnt, 4'b1000);
      addr[0] = 5'd9;
      step(4'b0001, 4'b0000, 1'b0, 1'b0);
      check("lit_wrap_0", o_gnt, 4'b0001);
      check("lit_wrap_addr", o_rf_addr, 5'd9);
      step(4'b0011, 4'b0000, 1'b0, 1'b0);
      check("lit_wrap_ptr1", o_gnt, 4'b0010);

      // Long sole-requester run with lock held, then a second requester joins
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(4'b0010, 4'b0010, 1'b0, 1'b0);
         check("lit_solo_gnt", o_gnt, 4'b0010);
      end
      step(4'b0011, 4'b0010, 1'b0, 1'b0);
      check("lit_solo_release", o_gnt, 4'b0001);

      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
